// File: rtl/instr_pkg.sv
// Shared definitions for the 9-bit instruction format and the program loader.
// Contents:
//   - instruction width and field positions (used by the loader and by the
//     instruction memory decode)
//   - loader state encoding
//   - rejection cause codes reported on err_code
//   - helper that checks a frame high byte
package instr_pkg;

    localparam int INSTR_W    = 9;
    localparam int FORMAT_BIT = 8;
    localparam int OPCODE_HI  = 7;
    localparam int OPCODE_LO  = 4;
    localparam int SIGN_BIT   = 3;
    localparam int OPERAND_HI = 2;
    localparam int OPERAND_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_LO,
        ST_HI,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } load_state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_COUNT  = 2'd1;
    localparam logic [1:0] ERR_HIBYTE = 2'd2;
    localparam logic [1:0] ERR_CSUM   = 2'd3;

    // A high byte carries only the format bit; every other bit must be zero.
    function automatic logic hi_byte_legal(input logic [7:0] b);
        return (b[7:1] == 7'd0);
    endfunction

endpackage

// File: rtl/instr_loader.sv
// Program loader for the 9-bit instruction memory.
// Receives a framed byte stream (count, low/high byte pairs, XOR checksum),
// rebuilds 9-bit instruction words and writes them through the memory write
// port. Reports a good load on done and a rejected load on error/err_code.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start             - one-cycle pulse that arms the loader (ignored while busy)
//   in_data/in_valid  - stream byte and its valid flag
//   in_ready          - loader accepts a byte this cycle (decoded from state)
//   wr_en/wr_addr/wr_data - registered instruction memory write port
//   busy              - a load is in progress
//   done              - sticky, last load completed with a good checksum
//   error/err_code    - sticky, last load rejected and why (0 when no error)
module instr_loader
    import instr_pkg::*;
#(
    parameter int DEPTH  = 55,
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [INSTR_W-1:0]  wr_data,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code
);

    localparam logic [7:0] DEPTH_MAX = 8'(DEPTH);

    load_state_t state;
    logic [7:0]  n_words;
    logic [7:0]  idx;
    logic [7:0]  xor_acc;
    logic        accept;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            ST_COUNT, ST_LO, ST_HI, ST_CSUM: in_ready = 1'b1;
            default:                         in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            n_words  <= 8'd0;
            idx      <= 8'd0;
            xor_acc  <= 8'd0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            // Write strobe is a single-cycle pulse; only the HI state raises it.
            wr_en <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state    <= ST_COUNT;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        err_code <= ERR_NONE;
                        idx      <= 8'd0;
                        xor_acc  <= 8'd0;
                    end
                end
                ST_COUNT: begin
                    if (accept) begin
                        n_words <= in_data;
                        xor_acc <= xor_acc ^ in_data;
                        if (in_data == 8'd0 || in_data > DEPTH_MAX) begin
                            state    <= ST_ERR;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= ERR_COUNT;
                        end else begin
                            state <= ST_LO;
                        end
                    end
                end
                ST_LO: begin
                    // The low byte goes straight into the write data register;
                    // it only changes outside the write strobe.
                    if (accept) begin
                        wr_data[OPCODE_HI:OPERAND_LO] <= in_data;
                        xor_acc <= xor_acc ^ in_data;
                        state   <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (accept) begin
                        xor_acc <= xor_acc ^ in_data;
                        if (!hi_byte_legal(in_data)) begin
                            state    <= ST_ERR;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= ERR_HIBYTE;
                        end else begin
                            wr_en               <= 1'b1;
                            wr_addr             <= ADDR_W'(idx);
                            wr_data[FORMAT_BIT] <= in_data[0];
                            idx                 <= idx + 8'd1;
                            // Index stops at N (<= DEPTH <= 255), so it never wraps.
                            if (idx + 8'd1 == n_words) begin
                                state <= ST_CSUM;
                            end else begin
                                state <= ST_LO;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (in_data == xor_acc) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_ERR;
                            error    <= 1'b1;
                            err_code <= ERR_CSUM;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader. Expected memory writes are queued
// when a frame is built and popped by a monitor whenever wr_en is seen.
module tb_instr_loader;
    import instr_pkg::*;

    localparam int DEPTH  = 55;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [8:0]        wr_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;

    instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [8:0]  data;
    } wr_t;

    typedef logic [7:0] bq_t[$];
    typedef logic [8:0] wq_t[$];

    wr_t exp_q[$];
    wr_t exp_e;
    int  n_tests  = 0;
    int  n_fail   = 0;
    int  wr_count = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                exp_e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(exp_e.addr));
                chk("wr_data", 32'(wr_data), 32'(exp_e.data));
            end
        end
    end

    // Builds count, byte pairs and XOR checksum; queues the expected writes.
    task automatic make_frame(input wq_t w, output bq_t f);
        logic [7:0] x;
        f = {};
        x = 8'(w.size());
        f.push_back(x);
        foreach (w[i]) begin
            f.push_back(w[i][7:0]);
            f.push_back({7'd0, w[i][8]});
            x = x ^ w[i][7:0] ^ {7'd0, w[i][8]};
            exp_q.push_back('{addr: 16'(i), data: w[i]});
        end
        f.push_back(x);
    endtask

    // Called on a falling edge; start is sampled on the following rising edge.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives bytes from a falling edge; optional 1-0-1 valid toggling.
    task automatic send(input bq_t f, input bit gaps, output int iters);
        int i;
        bit tog;
        bit acc;
        i = 0;
        tog = 1'b1;
        iters = 0;
        while (i < f.size() && iters < 1000) begin
            in_data  = f[i];
            in_valid = gaps ? tog : 1'b1;
            acc      = in_valid && in_ready;
            @(posedge clk);
            if (acc) i++;
            @(negedge clk);
            iters++;
            tog = ~tog;
        end
        in_valid = 1'b0;
        chk("bytes_accepted", 32'(i), 32'(f.size()));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_wr_en"},    32'(wr_en),    32'd0);
        chk({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
        chk({tag, "_wr_data"},  32'(wr_data),  32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_error"},    32'(error),    32'd0);
        chk({tag, "_err_code"}, 32'(err_code), 32'd0);
    endtask

    task automatic chk_end(input string tag, input bit exp_done, input bit exp_err,
                           input logic [1:0] exp_code);
        chk({tag, "_done"},     32'(done),        32'(exp_done));
        chk({tag, "_error"},    32'(error),       32'(exp_err));
        chk({tag, "_err_code"}, 32'(err_code),    32'(exp_code));
        chk({tag, "_busy"},     32'(busy),        32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready),    32'd0);
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bq_t f;
        bq_t f2;
        wq_t w;
        int  it;
        int  w0;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);

        // Good 3-word frame, valid held high. The checksum is the XOR of all
        // preceding bytes: 03^01^00^10^01^71^01 = 0x63.
        w = '{9'h001, 9'h110, 9'h171};
        make_frame(w, f);
        chk("t1_cksum", 32'(f[7]), 32'h63);
        do_start();
        chk("t1_busy_armed", 32'(busy), 32'd1);
        chk("t1_done_clear", 32'(done), 32'd0);
        send(f, 1'b0, it);
        chk("t1_frame_cycles", 32'(it), 32'd8);
        chk_end("t1", 1'b1, 1'b0, ERR_NONE);

        // Same frame with valid toggling.
        make_frame(w, f);
        do_start();
        w0 = wr_count;
        send(f, 1'b1, it);
        chk("t2_writes", 32'(wr_count - w0), 32'd3);
        chk_end("t2", 1'b1, 1'b0, ERR_NONE);

        // Bad count: zero, then one above DEPTH.
        f = '{8'h00};
        do_start();
        w0 = wr_count;
        send(f, 1'b0, it);
        chk_end("t3a", 1'b0, 1'b1, ERR_COUNT);
        in_valid = 1'b1;
        in_data  = 8'h01;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk("t3a_writes", 32'(wr_count - w0), 32'd0);
        chk("t3a_in_ready_after", 32'(in_ready), 32'd0);

        f = '{8'h38};
        do_start();
        w0 = wr_count;
        send(f, 1'b0, it);
        chk_end("t3b", 1'b0, 1'b1, ERR_COUNT);
        chk("t3b_writes", 32'(wr_count - w0), 32'd0);

        // Bad high byte.
        f = '{8'h01, 8'h25, 8'h02};
        do_start();
        w0 = wr_count;
        send(f, 1'b0, it);
        @(negedge clk);
        chk_end("t4", 1'b0, 1'b1, ERR_HIBYTE);
        chk("t4_writes", 32'(wr_count - w0), 32'd0);

        // Checksum mismatch: the word is written, then the frame is rejected.
        f = '{8'h01, 8'h25, 8'h01, 8'h00};
        exp_q.push_back('{addr: 16'd0, data: 9'h125});
        do_start();
        w0 = wr_count;
        send(f, 1'b0, it);
        chk_end("t5", 1'b0, 1'b1, ERR_CSUM);
        chk("t5_writes", 32'(wr_count - w0), 32'd1);

        // start while busy is ignored.
        f  = '{8'h01};
        f2 = '{8'h25, 8'h00, 8'h24};
        exp_q.push_back('{addr: 16'd0, data: 9'h025});
        do_start();
        send(f, 1'b0, it);
        do_start();
        chk("t6_busy_kept", 32'(busy), 32'd1);
        send(f2, 1'b0, it);
        chk_end("t6", 1'b1, 1'b0, ERR_NONE);

        // Largest legal frame: N = DEPTH.
        w = {};
        for (int i = 0; i < DEPTH; i++) w.push_back(9'($urandom));
        make_frame(w, f);
        do_start();
        w0 = wr_count;
        send(f, 1'b0, it);
        chk("t7_frame_cycles", 32'(it), 32'(2 * DEPTH + 2));
        chk("t7_writes", 32'(wr_count - w0), 32'(DEPTH));
        chk_end("t7", 1'b1, 1'b0, ERR_NONE);

        // Reset after the third byte, then re-arm with a 1-word frame.
        f = '{8'h03, 8'h01, 8'h00};
        exp_q.push_back('{addr: 16'd0, data: 9'h001});
        do_start();
        send(f, 1'b0, it);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t8_rst");
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h71;
        repeat (3) begin
            @(negedge clk);
            chk("t8_ignored_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        w = '{9'h1AB};
        make_frame(w, f);
        do_start();
        send(f, 1'b0, it);
        chk_end("t8", 1'b1, 1'b0, ERR_NONE);

        repeat (2) @(negedge clk);
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
